hist_acq_controller: RTL

//  Sequences the time-correlation histogram bin memory through CLEAR, ACQUIRE and READOUT.

---
 rtl/hist_acq_controller.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/hist_acq_controller.sv
`default_nettype none
// ============================================================================
// Module      : hist_acq_controller
// Description : Sequences the time-correlation histogram bin memory through
//               CLEAR, ACQUIRE and READOUT. Events are counted only inside a
//               programmable acquisition window. Bins are streamed to the host
//               over a valid/ready interface.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst_n              clock, synchronous active-low reset
//   cmd_valid/cmd/cmd_ready host command (01 CLEAR, 10 ACQUIRE, 11 READOUT)
//   abort                   return to IDLE immediately, no done pulse
//   win_len                 acquisition window length, latched with command
//   evt_valid/evt_bin       front-end delay-bin events
//   mem_addr/inc/clr/rd     registered bin memory strobes
//   mem_rdata               memory read data, valid 1 cycle after mem_rd
//   out_valid/ready/bin/data/last  readout stream
//   busy, done, evt_count   status
// ============================================================================
module hist_acq_controller #(
    parameter int BIN_ADDR_W = 7,
    parameter int BIN_W      = 8,
    parameter int WIN_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    input  logic [1:0]            cmd,
    output logic                  cmd_ready,
    input  logic                  abort,
    input  logic [WIN_W-1:0]      win_len,
    input  logic                  evt_valid,
    input  logic [BIN_ADDR_W-1:0] evt_bin,
    output logic [BIN_ADDR_W-1:0] mem_addr,
    output logic                  mem_inc,
    output logic                  mem_clr,
    output logic                  mem_rd,
    input  logic [BIN_W-1:0]      mem_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BIN_ADDR_W-1:0] out_bin,
    output logic [BIN_W-1:0]      out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done,
    output logic [WIN_W-1:0]      evt_count
);

    localparam logic [1:0]            c_CMD_CLEAR = 2'b01;
    localparam logic [1:0]            c_CMD_ACQ   = 2'b10;
    localparam logic [1:0]            c_CMD_READ  = 2'b11;
    localparam logic [BIN_ADDR_W-1:0] c_LAST_BIN  = '1;
    localparam logic [BIN_ADDR_W-1:0] c_BIN_ONE   = BIN_ADDR_W'(1);
    localparam logic [WIN_W-1:0]      c_WIN_ONE   = WIN_W'(1);
    localparam logic [WIN_W-1:0]      c_EVT_MAX   = '1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CLEAR    = 3'd1,
        S_ACQ      = 3'd2,
        S_RD_ISSUE = 3'd3,
        S_RD_WAIT  = 3'd4,
        S_RD_HOLD  = 3'd5
    } state_t;

    state_t                r_state;
    logic [BIN_ADDR_W-1:0] r_idx;
    logic [WIN_W-1:0]      r_win_cnt;

    state_t                w_state_nxt;
    logic [BIN_ADDR_W-1:0] w_idx_nxt;
    logic [WIN_W-1:0]      w_win_cnt_nxt;
    logic [BIN_ADDR_W-1:0] w_mem_addr_nxt;
    logic                  w_mem_inc_nxt;
    logic                  w_mem_clr_nxt;
    logic                  w_mem_rd_nxt;
    logic                  w_out_valid_nxt;
    logic                  w_out_last_nxt;
    logic [BIN_ADDR_W-1:0] w_out_bin_nxt;
    logic [BIN_W-1:0]      w_out_data_nxt;
    logic                  w_done_nxt;
    logic [WIN_W-1:0]      w_evt_count_nxt;

    assign cmd_ready = (r_state == S_IDLE);
    assign busy      = ~cmd_ready;

    // All memory strobes and stream outputs are computed here as next-cycle
    // values, so each strobe is visible in the same cycle as the state that
    // owns it (e.g. mem_clr is high in every CLEAR cycle).
    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_win_cnt_nxt   = r_win_cnt;
        w_mem_addr_nxt  = mem_addr;
        w_mem_inc_nxt   = 1'b0;
        w_mem_clr_nxt   = 1'b0;
        w_mem_rd_nxt    = 1'b0;
        w_out_valid_nxt = 1'b0;
        w_out_last_nxt  = 1'b0;
        w_out_bin_nxt   = out_bin;
        w_out_data_nxt  = out_data;
        w_done_nxt      = 1'b0;
        w_evt_count_nxt = evt_count;

        if (abort) begin
            // Strobes and out_valid fall to their defaults; evt_count is kept.
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        case (cmd)
                            c_CMD_CLEAR: begin
                                w_state_nxt    = S_CLEAR;
                                w_idx_nxt      = '0;
                                w_mem_clr_nxt  = 1'b1;
                                w_mem_addr_nxt = '0;
                            end
                            c_CMD_ACQ: begin
                                w_evt_count_nxt = '0;
                                if (win_len == '0) begin
                                    // Zero-length window: complete at once.
                                    w_done_nxt = 1'b1;
                                end else begin
                                    w_state_nxt   = S_ACQ;
                                    w_win_cnt_nxt = win_len;
                                end
                            end
                            c_CMD_READ: begin
                                w_state_nxt    = S_RD_ISSUE;
                                w_idx_nxt      = '0;
                                w_mem_rd_nxt   = 1'b1;
                                w_mem_addr_nxt = '0;
                            end
                            default: ;
                        endcase
                    end
                end

                S_CLEAR: begin
                    if (r_idx == c_LAST_BIN) begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_idx_nxt      = r_idx + c_BIN_ONE;
                        w_mem_clr_nxt  = 1'b1;
                        w_mem_addr_nxt = r_idx + c_BIN_ONE;
                    end
                end

                S_ACQ: begin
                    if (evt_valid) begin
                        w_mem_inc_nxt  = 1'b1;
                        w_mem_addr_nxt = evt_bin;
                        if (evt_count != c_EVT_MAX) begin
                            w_evt_count_nxt = evt_count + c_WIN_ONE;
                        end
                    end
                    // r_win_cnt is never zero here; 1 marks the final cycle.
                    if (r_win_cnt == c_WIN_ONE) begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_win_cnt_nxt = r_win_cnt - c_WIN_ONE;
                    end
                end

                S_RD_ISSUE: begin
                    w_state_nxt = S_RD_WAIT;
                end

                S_RD_WAIT: begin
                    // Read data for r_idx is present on mem_rdata this cycle.
                    w_state_nxt     = S_RD_HOLD;
                    w_out_data_nxt  = mem_rdata;
                    w_out_bin_nxt   = r_idx;
                    w_out_valid_nxt = 1'b1;
                    w_out_last_nxt  = (r_idx == c_LAST_BIN);
                end

                S_RD_HOLD: begin
                    w_out_valid_nxt = 1'b1;
                    w_out_last_nxt  = out_last;
                    if (out_ready) begin
                        w_out_valid_nxt = 1'b0;
                        w_out_last_nxt  = 1'b0;
                        if (r_idx == c_LAST_BIN) begin
                            w_state_nxt = S_IDLE;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_state_nxt    = S_RD_ISSUE;
                            w_idx_nxt      = r_idx + c_BIN_ONE;
                            w_mem_rd_nxt   = 1'b1;
                            w_mem_addr_nxt = r_idx + c_BIN_ONE;
                        end
                    end
                end

                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_win_cnt <= '0;
            mem_addr  <= '0;
            mem_inc   <= 1'b0;
            mem_clr   <= 1'b0;
            mem_rd    <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_bin   <= '0;
            out_data  <= '0;
            done      <= 1'b0;
            evt_count <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_win_cnt <= w_win_cnt_nxt;
            mem_addr  <= w_mem_addr_nxt;
            mem_inc   <= w_mem_inc_nxt;
            mem_clr   <= w_mem_clr_nxt;
            mem_rd    <= w_mem_rd_nxt;
            out_valid <= w_out_valid_nxt;
            out_last  <= w_out_last_nxt;
            out_bin   <= w_out_bin_nxt;
            out_data  <= w_out_data_nxt;
            done      <= w_done_nxt;
            evt_count <= w_evt_count_nxt;
        end
    end

endmodule
`default_nettype wire
